// File: rtl/prog_loader_if.sv
// Byte-stream input and RAM write port of the program loader.
interface prog_loader_if;
  logic [7:0]  inData;
  logic        inValid;
  logic        inReady;
  logic        memWE;
  logic [31:0] memAddr;
  logic [31:0] memData;

  modport master (
    output inData, inValid,
    input  inReady, memWE, memAddr, memData
  );

  modport slave (
    input  inData, inValid,
    output inReady, memWE, memAddr, memData
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: length-prefixed little-endian byte stream to 32-bit RAM writes,
// then releases the CPU.
module prog_loader #(
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  prog_loader_if.slave      bus,
  output logic              cpuRun,
  output logic              loadError,
  output logic [31:0]       wordsLoaded
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

  localparam logic [31:0] MaxWords = 32'(MAX_WORDS);

  state_t      state, stateNext;
  logic [1:0]  byteCnt;
  logic [23:0] partial;
  logic [31:0] wordCount;
  logic [31:0] wordIdx;
  logic        weReg;
  logic        accept;
  logic        lastByte;
  logic        writeNow;
  logic        restartNow;
  logic [31:0] assembled;

  assign bus.inReady = reset && (state != DONE);
  assign accept      = bus.inValid && bus.inReady;
  assign lastByte    = accept && (byteCnt == 2'd3);
  assign writeNow    = (state == LOAD) && lastByte;
  assign restartNow  = ((state == DONE) || (state == ERROR)) && restart;
  assign assembled   = {bus.inData, partial};
  // A write registered just before reset must not appear while reset is held.
  assign bus.memWE   = weReg && reset;
  assign loadError   = (state == ERROR);

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (lastByte) begin
          if (assembled == '0)
            stateNext = DONE;
          else if (assembled > MaxWords)
            stateNext = ERROR;
          else
            stateNext = LOAD;
        end
      end
      LOAD: begin
        if (lastByte && (wordIdx == wordCount - 32'd1))
          stateNext = DONE;
      end
      DONE, ERROR: begin
        if (restart)
          stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      byteCnt     <= '0;
      partial     <= '0;
      wordCount   <= '0;
      wordIdx     <= '0;
      weReg       <= 1'b0;
      bus.memAddr <= '0;
      bus.memData <= '0;
      cpuRun      <= 1'b0;
      wordsLoaded <= '0;
    end else begin
      state  <= stateNext;
      weReg  <= writeNow;
      // Rises the cycle after DONE is entered, drops as soon as restart leaves DONE.
      cpuRun <= (state == DONE) && (stateNext == DONE);
      if (restartNow) begin
        byteCnt     <= '0;
        partial     <= '0;
        wordCount   <= '0;
        wordIdx     <= '0;
        wordsLoaded <= '0;
      end else if (accept && ((state == IDLE) || (state == LOAD))) begin
        byteCnt <= byteCnt + 2'd1;
        partial <= {bus.inData, partial[23:8]};
        if (lastByte) begin
          if (state == IDLE) begin
            wordCount <= assembled;
            wordIdx   <= '0;
          end else begin
            bus.memAddr <= wordIdx;
            bus.memData <= assembled;
            wordsLoaded <= wordsLoaded + 32'd1;
            if (wordIdx != wordCount - 32'd1)
              wordIdx <= wordIdx + 32'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: stream-level reference model plus directed loads.
module tb_prog_loader;
  localparam int unsigned MAXW = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        restart = 1'b0;
  logic        cpuRun;
  logic        loadError;
  logic [31:0] wordsLoaded;

  prog_loader_if bus ();

  prog_loader #(.MAX_WORDS(MAXW)) dut (
    .clk         (clk),
    .reset       (reset),
    .restart     (restart),
    .bus         (bus.slave),
    .cpuRun      (cpuRun),
    .loadError   (loadError),
    .wordsLoaded (wordsLoaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: counts accepted bytes since the last IDLE entry.
  logic        mStarted = 1'b0;
  logic        mDone = 1'b0;
  logic        mErr = 1'b0;
  logic        mWE = 1'b0;
  logic        mRun = 1'b0;
  logic        mAcc = 1'b0;
  logic [31:0] mN = '0;
  logic [31:0] mWords = '0;
  logic [31:0] mAddr = '0;
  logic [31:0] mData = '0;
  logic [31:0] mWord = '0;
  int unsigned mBytes = 0;

  always @(posedge clk) begin : model
    logic        nDone, nErr, nWE, nAcc;
    logic [31:0] nN, nWords, nAddr, nData, nWord;
    int unsigned nBytes;
    nDone = mDone; nErr = mErr; nN = mN; nWords = mWords;
    nAddr = mAddr; nData = mData; nWord = mWord; nBytes = mBytes;
    nWE = 1'b0; nAcc = 1'b0;
    if (!reset) begin
      nDone = 1'b0; nErr = 1'b0; nN = '0; nWords = '0;
      nAddr = '0; nData = '0; nWord = '0; nBytes = 0;
    end else if ((mDone || mErr) && restart) begin
      nDone = 1'b0; nErr = 1'b0; nN = '0; nWords = '0; nWord = '0; nBytes = 0;
    end else if (bus.inValid && !mDone) begin
      nAcc = 1'b1;
      if (!mErr) begin
        nWord[8*(mBytes%4) +: 8] = bus.inData;
        nBytes = mBytes + 1;
        if (nBytes == 4) begin
          nN = nWord;
          if (nWord == 0) nDone = 1'b1;
          else if (nWord > MAXW) nErr = 1'b1;
        end else if (nBytes % 4 == 0) begin
          nWE    = 1'b1;
          nAddr  = 32'((nBytes - 8) / 4);
          nData  = nWord;
          nWords = mWords + 32'd1;
          if (nAddr == mN - 32'd1) nDone = 1'b1;
        end
      end
    end
    mRun     <= reset && mDone && nDone;
    mDone    <= nDone;
    mErr     <= nErr;
    mN       <= nN;
    mWords   <= nWords;
    mAddr    <= nAddr;
    mData    <= nData;
    mWord    <= nWord;
    mBytes   <= nBytes;
    mWE      <= nWE;
    mAcc     <= nAcc;
    mStarted <= 1'b1;
  end

  int          wrCount = 0;
  logic [31:0] wrAddr [64];
  logic [31:0] wrData [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareCycle();
    logic expWE;
    expWE = mWE && reset;
    chk("inReady", 32'(bus.inReady), 32'(reset && !mDone));
    chk("memWE", 32'(bus.memWE), 32'(expWE));
    if (expWE) begin
      chk("memAddr", bus.memAddr, mAddr);
      chk("memData", bus.memData, mData);
    end
    chk("cpuRun", 32'(cpuRun), 32'(mRun));
    chk("loadError", 32'(loadError), 32'(mErr));
    chk("wordsLoaded", wordsLoaded, mWords);
    if (bus.memWE === 1'b1) begin
      wrAddr[wrCount % 64] = bus.memAddr;
      wrData[wrCount % 64] = bus.memData;
      wrCount++;
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic rs);
    bus.inValid = v;
    bus.inData  = d;
    restart     = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) cyc(1'b1, w[8*i +: 8], 1'b0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int          base;
    logic [31:0] w;
    bus.inValid = 1'b0;
    bus.inData  = 8'h00;
    fork
      forever begin
        @(negedge clk);
        if (mStarted) compareCycle();
      end
    join_none

    // Reset state
    idle(2);
    chk("rst memAddr", bus.memAddr, 32'h0);
    chk("rst memData", bus.memData, 32'h0);
    chk("rst wordsLoaded", wordsLoaded, 32'h0);
    chk("rst inReady", 32'(bus.inReady), 32'h0);
    reset = 1'b1;
    idle(1);
    chk("first inReady", 32'(bus.inReady), 32'h1);

    // Two-word back-to-back load
    base = wrCount;
    sendWord(32'd2);
    sendWord(32'h12345678);
    sendWord(32'hDEADBEEF);
    idle(3);
    chk("two-word count", 32'(wrCount - base), 32'd2);
    chk("two-word addr0", wrAddr[base % 64], 32'd0);
    chk("two-word data0", wrData[base % 64], 32'h12345678);
    chk("two-word addr1", wrAddr[(base + 1) % 64], 32'd1);
    chk("two-word data1", wrData[(base + 1) % 64], 32'hDEADBEEF);
    chk("two-word cpuRun", 32'(cpuRun), 32'h1);
    chk("two-word wordsLoaded", wordsLoaded, 32'd2);
    cyc(1'b0, 8'h00, 1'b1);
    idle(1);

    // Empty program
    base = wrCount;
    sendWord(32'd0);
    idle(2);
    chk("empty cpuRun", 32'(cpuRun), 32'h1);
    chk("empty wordsLoaded", wordsLoaded, 32'd0);
    chk("empty writes", 32'(wrCount - base), 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    idle(1);

    // Oversized header
    base = wrCount;
    sendWord(MAXW + 1);
    chk("oversize loadError", 32'(loadError), 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("oversize inReady", 32'(bus.inReady), 32'h1);
      cyc(1'b1, 8'(i + 8'h30), 1'b0);
    end
    idle(2);
    chk("oversize writes", 32'(wrCount - base), 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("oversize cleared", 32'(loadError), 32'h0);
    idle(1);

    // Single word with toggled valid and gaps
    base = wrCount;
    w = 32'd1;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, (i < 4) ? w[8*i +: 8] : 8'(8'h44 - 8'((i - 4) * 8'h11)), 1'b0);
      cyc(1'b0, 8'hFF, 1'b0);
      if (i % 2 == 1) idle(3);
    end
    idle(2);
    chk("gappy count", 32'(wrCount - base), 32'd1);
    chk("gappy addr", wrAddr[base % 64], 32'd0);
    chk("gappy data", wrData[base % 64], 32'h11223344);
    cyc(1'b0, 8'h00, 1'b1);
    idle(1);

    // Reset right after the last byte of word 0
    base = wrCount;
    sendWord(32'd1);
    sendWord(32'h55667788);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    chk("abort writes", 32'(wrCount - base), 32'd0);
    chk("abort cpuRun", 32'(cpuRun), 32'h0);
    chk("abort wordsLoaded", wordsLoaded, 32'd0);
    chk("abort memAddr", bus.memAddr, 32'd0);
    chk("abort memData", bus.memData, 32'd0);
    sendWord(32'd1);
    sendWord(32'hCAFEF00D);
    idle(2);
    chk("reload count", 32'(wrCount - base), 32'd1);
    chk("reload addr", wrAddr[base % 64], 32'd0);
    chk("reload data", wrData[base % 64], 32'hCAFEF00D);

    // Restart colliding with a byte in DONE
    cyc(1'b1, 8'h02, 1'b1);
    chk("collide cpuRun", 32'(cpuRun), 32'h0);
    chk("collide inReady", 32'(bus.inReady), 32'h1);
    base = wrCount;
    sendWord(32'd2);
    sendWord(32'hA1B2C3D4);
    sendWord(32'h0BADF00D);
    idle(2);
    chk("collide count", 32'(wrCount - base), 32'd2);
    chk("collide data1", wrData[(base + 1) % 64], 32'h0BADF00D);
    chk("collide cpuRun after", 32'(cpuRun), 32'h1);
    cyc(1'b0, 8'h00, 1'b1);
    idle(1);

    // Randomized loads
    for (int t = 0; t < 16; t++) begin
      logic [7:0]  q[$];
      logic [31:0] n;
      int          cycles;
      logic        v;
      n = $urandom_range(0, MAXW + 2);
      for (int i = 0; i < 4; i++) q.push_back(n[8*i +: 8]);
      for (int i = 0; i < int'(n) * 4; i++) q.push_back(8'($urandom));
      cycles = 0;
      while (!(mDone || mErr) && cycles < 400) begin
        v = (($urandom % 4) != 0) && (q.size() > 0);
        cyc(v, (q.size() > 0) ? q[0] : 8'($urandom), (($urandom % 8) == 0));
        if (mAcc && q.size() > 0) void'(q.pop_front());
        cycles++;
      end
      chk("random load completes", 32'(cycles < 400), 32'h1);
      for (int i = 0; i < 3; i++) cyc(1'($urandom), 8'($urandom), 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      idle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: MAX_WORDS, default 1024, maximum program length in 32-bit words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 inData  input  8  program byte stream.
REQ-005 inValid  input  1  inData valid this cycle.
REQ-006 inReady  output  1  loader accepts a byte this cycle.
REQ-007 restart  input  1  return from DONE/ERROR to IDLE for a new load.
REQ-008 memWE  output  1  one-cycle RAM write strobe.
REQ-009 memAddr  output  32  RAM word address of the write.
REQ-010 memData  output  32  RAM write data.
REQ-011 cpuRun  output  1  program loaded; CPU may leave reset.
REQ-012 loadError  output  1  header length exceeded MAX_WORDS.
REQ-013 wordsLoaded  output  32  count of words written since the last IDLE entry.

Function
REQ-014 A byte transfers only in a cycle where inValid=1 and inReady=1.
REQ-015 States SHALL be IDLE (collect header), LOAD (collect payload), DONE, ERROR.
REQ-016 inReady SHALL be 1 in IDLE, LOAD and ERROR, and 0 in DONE.
REQ-017 Stream format: 4-byte little-endian word count N, then N words, each 4 bytes, little-endian (first byte = bits 7:0).
REQ-018 IDLE: on the 4th header byte, N==0 -> DONE; N>MAX_WORDS -> ERROR; otherwise -> LOAD with word index 0.
REQ-019 LOAD: on the 4th byte of word k, the cycle after SHALL show memWE=1, memAddr=k, memData=assembled word, for exactly one cycle.
REQ-020 Back-to-back bytes SHALL be accepted at 1 byte/cycle with no stall; the write pipeline never backpressures.
REQ-021 wordsLoaded SHALL increment in the same cycle memWE is asserted.
REQ-022 After the write of word N-1, the state SHALL be DONE in the same cycle memWE is high, so cpuRun=1 from the following cycle's register value onward, i.e. cpuRun rises 1 cycle after the final memWE.
REQ-023 memWE SHALL be 0 in IDLE, DONE and ERROR except for the pending final write of REQ-022.
REQ-024 ERROR: loadError=1; incoming bytes are accepted and discarded; no memWE.
REQ-025 restart in DONE or ERROR -> IDLE next cycle: cpuRun=0, loadError=0, wordsLoaded=0, byte/word counters cleared; restart in IDLE/LOAD SHALL be ignored.
REQ-026 restart and inValid in the same DONE cycle: restart wins; no byte is accepted (inReady=0).
REQ-027 Byte counter wraps 3->0 per word; word index SHALL never exceed N-1 and never wraps.
REQ-028 Partial words at any state exit SHALL be discarded, never written.

Reset
REQ-029 reset=0 at a clock edge SHALL force IDLE, memWE=0, memAddr=0, memData=0, cpuRun=0, loadError=0, wordsLoaded=0, all counters 0.
REQ-030 Reset mid-LOAD SHALL abandon the load and suppress any pending write in the next cycle.
REQ-031 inReady SHALL be 0 while reset=0, and 1 in the first cycle after release (IDLE).

Verification
REQ-032 Stream 02 00 00 00, 78 56 34 12, EF BE AD DE, inValid held high -> memWE at addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF; cpuRun=1 one cycle after 2nd write; wordsLoaded=2.
REQ-033 Header 00 00 00 00 -> DONE directly, no memWE, cpuRun=1, wordsLoaded=0.
REQ-034 Header N=MAX_WORDS+1 -> loadError=1, no memWE, following bytes accepted with inReady=1; restart -> IDLE, loadError=0.
REQ-035 N=1 with inValid toggled 1/0 every cycle and gaps of 3 cycles -> single write, correct data, no spurious memWE.
REQ-036 reset=0 asserted one cycle after 4th byte of word 0 -> no memWE, all outputs zero; reload of N=1 afterwards succeeds at addr 0.
REQ-037 In DONE, restart=1 with inValid=1 -> byte not consumed, IDLE next cycle, cpuRun=0; a new 2-word load then completes normally.
